// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative HI/LO multiply/divide unit for a MIPS-style core.
// Multiply uses radix-2 shift-add. Divide uses radix-2 restoring subtraction.
// Each takes one iteration per data bit and then one sign-fix cycle.
// MTHI/MTLO write HI/LO at the next edge and never set busy or done.
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   start           - request strobe, sampled together with funct/op_a/op_b
//   funct[5:0]      - R-type funct code (MULT, MULTU, DIV, DIVU, MTHI, MTLO)
//   op_a, op_b      - rs / rt operand values
//   busy            - an iterative operation is in progress
//   done            - one-cycle pulse when HI/LO hold a new mul/div result
//   div_zero        - divisor was zero (valid only while done=1)
//   hi, lo          - HI / LO registers
module mips_muldiv #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [5:0]            funct,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [DW-1:0]    r_upper, w_upper_nxt;   // product high half / partial remainder
    logic [DW-1:0]    r_lower, w_lower_nxt;   // multiplier bits / dividend bits -> quotient
    logic [DW-1:0]    r_mcand, w_mcand_nxt;   // multiplicand or divisor magnitude
    logic             r_is_div, w_is_div_nxt;
    logic             r_neg_q, w_neg_q_nxt;   // product/quotient sign
    logic             r_neg_r, w_neg_r_nxt;   // remainder sign
    logic             r_b_zero, w_b_zero_nxt;
    logic [DW-1:0]    r_hi, w_hi_nxt;
    logic [DW-1:0]    r_lo, w_lo_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_div_zero, w_div_zero_nxt;

    // Operand conditioning for the accept cycle
    logic          w_signed, w_a_neg, w_b_neg;
    logic [DW-1:0] w_a_mag, w_b_mag;
    // Iteration datapath
    logic [DW:0]   w_mul_sum, w_div_shift, w_div_diff;
    logic [2*DW-1:0] w_prod;
    logic [DW-1:0]   w_quot, w_rem;

    always_comb begin
        w_signed    = (funct == F_MULT) || (funct == F_DIV);
        w_a_neg     = w_signed & op_a[DW-1];
        w_b_neg     = w_signed & op_b[DW-1];
        w_a_mag     = w_a_neg ? (DW'(0) - op_a) : op_a;
        w_b_mag     = w_b_neg ? (DW'(0) - op_b) : op_b;

        w_mul_sum   = {1'b0, r_upper} + (r_lower[0] ? {1'b0, r_mcand} : (DW+1)'(0));
        w_div_shift = {r_upper, r_lower[DW-1]};
        w_div_diff  = w_div_shift - {1'b0, r_mcand};

        w_prod      = r_neg_q ? ((2*DW)'(0) - {r_upper, r_lower}) : {r_upper, r_lower};
        w_quot      = r_neg_q ? (DW'(0) - r_lower) : r_lower;
        w_rem       = r_neg_r ? (DW'(0) - r_upper) : r_upper;
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_upper_nxt    = r_upper;
        w_lower_nxt    = r_lower;
        w_mcand_nxt    = r_mcand;
        w_is_div_nxt   = r_is_div;
        w_neg_q_nxt    = r_neg_q;
        w_neg_r_nxt    = r_neg_r;
        w_b_zero_nxt   = r_b_zero;
        w_hi_nxt       = r_hi;
        w_lo_nxt       = r_lo;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_div_zero_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (funct)
                        F_MTHI: w_hi_nxt = op_a;
                        F_MTLO: w_lo_nxt = op_a;
                        F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                            w_state_nxt  = S_RUN;
                            w_busy_nxt   = 1'b1;
                            w_cnt_nxt    = '0;
                            w_is_div_nxt = funct[1];
                            w_neg_q_nxt  = w_a_neg ^ w_b_neg;
                            w_neg_r_nxt  = w_a_neg;
                            w_b_zero_nxt = (op_b == '0);
                            w_upper_nxt  = '0;
                            if (funct[1]) begin
                                w_lower_nxt = w_a_mag;
                                w_mcand_nxt = w_b_mag;
                            end else begin
                                w_lower_nxt = w_b_mag;
                                w_mcand_nxt = w_a_mag;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_is_div) begin
                    // Restoring step: keep the difference only when it did not borrow
                    if (!w_div_diff[DW]) begin
                        w_upper_nxt = w_div_diff[DW-1:0];
                        w_lower_nxt = {r_lower[DW-2:0], 1'b1};
                    end else begin
                        w_upper_nxt = w_div_shift[DW-1:0];
                        w_lower_nxt = {r_lower[DW-2:0], 1'b0};
                    end
                end else begin
                    w_upper_nxt = w_mul_sum[DW:1];
                    w_lower_nxt = {w_mul_sum[0], r_lower[DW-1:1]};
                end
                if (r_cnt == CNT_W'(DW - 1)) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt    = S_IDLE;
                w_busy_nxt     = 1'b0;
                w_done_nxt     = 1'b1;
                w_div_zero_nxt = r_is_div & r_b_zero;
                if (r_is_div) begin
                    // Zero divisor leaves remainder = |a|, so sign-fixing restores op_a
                    w_lo_nxt = r_b_zero ? '1 : w_quot;
                    w_hi_nxt = w_rem;
                end else begin
                    w_hi_nxt = w_prod[2*DW-1:DW];
                    w_lo_nxt = w_prod[DW-1:0];
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_upper    <= '0;
            r_lower    <= '0;
            r_mcand    <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_b_zero   <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_upper    <= w_upper_nxt;
            r_lower    <= w_lower_nxt;
            r_mcand    <= w_mcand_nxt;
            r_is_div   <= w_is_div_nxt;
            r_neg_q    <= w_neg_q_nxt;
            r_neg_r    <= w_neg_r_nxt;
            r_b_zero   <= w_b_zero_nxt;
            r_hi       <= w_hi_nxt;
            r_lo       <= w_lo_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_div_zero <= w_div_zero_nxt;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: doc/mips_muldiv.md
MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning operand and HI/LO register width (equal to DATA_MEM_WIDTH).
REQ-002 SHALL have port clk, input, 1, meaning single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, meaning request strobe, sampled with funct/op_a/op_b.
REQ-005 SHALL have port funct, input, 6, meaning R-type funct_t code (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
REQ-006 SHALL have port op_a, input, DATA_WIDTH, meaning rs value (multiplicand, dividend, or MTHI/MTLO data).
REQ-007 SHALL have port op_b, input, DATA_WIDTH, meaning rt value (multiplier or divisor).
REQ-008 SHALL have port busy, output, 1, meaning an iterative operation is in progress.
REQ-009 SHALL have port done, output, 1, meaning one-cycle pulse when HI/LO hold a new mul/div result.
REQ-010 SHALL have port div_zero, output, 1, meaning divisor was zero; valid only while done=1, else 0.
REQ-011 SHALL have port hi, output, DATA_WIDTH, meaning HI register (read by MFHI).
REQ-012 SHALL have port lo, output, DATA_WIDTH, meaning LO register (read by MFLO).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIX.
- IDLE -> RUN: start=1 with funct in {MULT, MULTU, DIV, DIVU}.
- RUN -> FIX: after 32 iterations.
- FIX -> IDLE: unconditional.
REQ-014 SHALL, on accept at edge E0, latch operand magnitudes (two's-complement abs for MULT/DIV, raw for MULTU/DIVU), the result-sign flags, and the op type, and clear the 5-bit iteration counter.
REQ-015 SHALL perform one radix-2 step per RUN cycle: shift-add for multiply, restoring subtract for divide; the counter SHALL wrap 31 -> 0 on the transition to FIX at E32.
REQ-016 SHALL, at the FIX edge E33, apply sign correction and write hi/lo; busy SHALL be 1 in the cycles after E0 through E32, and 0 with done=1 in the cycle after E33.
REQ-017 Multiply results SHALL be hi = product[63:32] and lo = product[31:0]; MULT SHALL negate the 64-bit product when sign(a) XOR sign(b).
REQ-018 Divide results SHALL be lo = quotient and hi = remainder; DIV quotient sign SHALL be sign(a) XOR sign(b) and remainder sign SHALL be sign(a) (truncating division).
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo = 0x80000000 and hi = 0 with no error flag.
REQ-020 A divisor of 0 (DIV or DIVU) SHALL still take the full latency, yield lo = all ones and hi = op_a, and assert div_zero with done.
REQ-021 MTHI or MTLO with start=1 in IDLE SHALL write op_a to hi or lo at the next edge; busy and done SHALL stay 0 and the other register SHALL be unchanged.
REQ-022 start SHALL be ignored while in RUN or FIX; hi and lo SHALL hold their previous values until the FIX edge.
REQ-023 start with any other funct SHALL be ignored.
REQ-024 start SHALL be accepted in the same cycle that done=1 (state is IDLE).
REQ-025 hi and lo SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL go to IDLE with hi=0, lo=0, busy=0, done=0, div_zero=0, and the counter and datapath registers cleared.
REQ-027 Reset mid-operation SHALL abort the operation with no partial HI/LO write; rst SHALL take priority over start.

Verification
REQ-028 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 34 cycles after the start cycle.
REQ-029 MULT 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-030 DIVU 0x64 / 0 -> lo=0xFFFFFFFF, hi=0x64, div_zero=1 for the done cycle only.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, div_zero=0.
REQ-032 MTHI 0x12345678 then MTLO 0x9ABCDEF0 on back-to-back cycles -> hi and lo updated one cycle each, done never asserted.
REQ-033 Issue MULTU, then a second start at cycle 10 (ignored), then rst at cycle 20 -> busy=0, hi=lo=0, no done pulse; a new DIVU 9/4 then yields lo=2, hi=1.
